my_image_ip_s00_axis_rx: RTL and testbench
==========================================

# my_image_ip_s00_axis_rx

AXI4-Stream slave receiver that takes image beats from the DMA MM2S channel and feeds the IP's internal processing logic. It buffers beats in a small first-word-fall-through FIFO and presents a valid/ready interface to the top logic. It counts accepted beats per frame and reports completed frames. It is the inbound counterpart of the IP's outbound M00_AXIS stream port.

## Interface
Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, data width; multiple of 8.
- FIFO_DEPTH, 16, buffer entries; power of two, at least 2.
- FRAME_WORDS, 1024, expected beats per frame; at least 1.

Ports:
- S_AXIS_ACLK  in  1  single clock for all logic.
- S_AXIS_ARESET  in  1  synchronous, active-high reset.
- S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  beat data from the DMA.
- S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  accepted but ignored; all bytes are treated as valid.
- S_AXIS_TLAST  in  1  end of frame.
- S_AXIS_TVALID  in  1  beat valid.
- S_AXIS_TREADY  out  1  high when the FIFO is not full.
- data_out  out  C_S_AXIS_TDATA_WIDTH  FIFO head data, to the top logic.
- last_out  out  1  TLAST stored with the FIFO head.
- valid_out  out  1  FIFO not empty.
- ready_in  in  1  top logic consumes the head.
- frame_done  out  1  one-cycle pulse per accepted TLAST beat.
- frame_cnt  out  16  count of completed frames; wraps from 0xFFFF to 0.
- err_short  out  1  sticky: TLAST arrived before beat FRAME_WORDS.
- err_long  out  1  sticky: beat FRAME_WORDS arrived without TLAST.
- err_clr  in  1  clears both error flags.

## Operation
- Push occurs when S_AXIS_TVALID && S_AXIS_TREADY. It writes {TLAST, TDATA} at the write pointer.
- Pop occurs when valid_out && ready_in. It advances the read pointer.
- data_out and last_out are read combinationally from the read pointer. Their value is don't-care while valid_out is low.
- Occupancy count ranges 0..FIFO_DEPTH.
  - Push alone: count +1.
  - Pop alone: count −1.
  - Push and pop in the same cycle: count unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- S_AXIS_TREADY = (count != FIFO_DEPTH). Because of this, a push is never attempted when full.
- Pop while empty cannot occur.
- Beat counter is $clog2(FRAME_WORDS)+1 bits and increments on each push.
- On a push with TLAST:
  - If beat_cnt+1 < FRAME_WORDS, set err_short.
  - Reset beat_cnt to 0.
  - frame_done pulses on the next cycle; frame_cnt increments on the same edge.
- On a push without TLAST where beat_cnt+1 == FRAME_WORDS:
  - Set err_long.
  - Keep counting, saturating at the maximum value, until TLAST arrives.
- err_clr has lower priority than a same-cycle error set: the error is set.
- The block never drops, reorders, or modifies a beat. Frame errors are report-only.

## Timing
- All outputs update on the rising edge of S_AXIS_ACLK.
- Reset values:
  - S_AXIS_TREADY = 0 during reset, 1 from the first cycle after reset deasserts.
  - valid_out = 0, frame_done = 0, frame_cnt = 0, err_short = 0, err_long = 0.
  - Pointers, count and beat_cnt = 0.
- Latency: a beat accepted on edge N gives valid_out = 1 from edge N onward. That is one cycle from TVALID to valid_out.
- Full: S_AXIS_TREADY drops in the cycle after the edge on which count reaches FIFO_DEPTH. It rises the cycle after the first pop.
- Reset mid-frame: the FIFO contents are discarded and the partial frame is forgotten. No error is flagged.
- Throughput: one beat per cycle in and one beat per cycle out, sustained, whenever the FIFO is neither full nor empty.

## Configuration
- MY_IMAGE_IP_FRAME_CHECK_EN: when defined, the beat counter, err_short, err_long and err_clr logic are compiled in.
- When not defined:
  - err_short and err_long are tied to 0.
  - err_clr is unused.
  - The beat counter is removed.
  - frame_done and frame_cnt still operate, driven from TLAST alone.

## Structure
- Shared package my_image_ip_pkg holds:
  - the FIFO entry type {last, data};
  - the FRAME_CNT_W = 16 constant;
  - the pointer-width function.
- Sub-module my_image_ip_sync_fifo is a parameterised FWFT synchronous FIFO with push, pop, full, empty and count. The frame counter and error logic stay in the top of this block.

## Test plan
- Reset, then 4 beats with TVALID held high and ready_in = 1 → data_out matches 0x0..0x3 in order; valid_out rises 1 cycle after the first accept; TREADY stays 1.
- ready_in = 0 with FIFO_DEPTH = 16 and 20 beats offered → exactly 16 beats accepted; TREADY = 0 from the cycle after the 16th accept. Raising ready_in then drains all 20 beats in order.
- FRAME_WORDS = 8, TLAST on beat 8 → one frame_done pulse, frame_cnt = 1, no errors.
- FRAME_WORDS = 8, TLAST on beat 5 → err_short = 1 and stays set. err_clr then returns it to 0.
- FRAME_WORDS = 8, TLAST on beat 10 → err_long set on beat 8; frame_done pulses after beat 10; the next 8-beat frame raises no new error.
- Reset asserted after 3 beats of a frame → all outputs return to reset values. A following 8-beat frame completes cleanly.

Source files
------------

// File: rtl/my_image_ip_pkg.sv
// rtl/my_image_ip_pkg.sv - shared types, constants and helpers for the my_image_ip stream ports
package my_image_ip_pkg;

    localparam int FRAME_CNT_W     = 16;
    localparam int DEFAULT_TDATA_W = 32;

    // FIFO entry layout at the default beat width; the receiver mirrors this shape at its own width.
    typedef struct packed {
        logic                       last;
        logic [DEFAULT_TDATA_W-1:0] data;
    } fifo_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/my_image_ip_sync_fifo.sv
// rtl/my_image_ip_sync_fifo.sv - parameterised first-word-fall-through synchronous FIFO
module my_image_ip_sync_fifo
    import my_image_ip_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [ptr_w(DEPTH):0]   count_o
);

    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             push_en, pop_en;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Internal guards keep the pointers coherent even if a caller misbehaves.
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/my_image_ip_s00_axis_rx.sv
// rtl/my_image_ip_s00_axis_rx.sv - AXI4-Stream slave receiver with FWFT buffer and frame tracking
// Frame length checking (beat counter, err_short/err_long/err_clr) is built only with MY_IMAGE_IP_FRAME_CHECK_EN.
module my_image_ip_s00_axis_rx
    import my_image_ip_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16,
    parameter int FRAME_WORDS          = 1024
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   data_out,
    output logic                              last_out,
    output logic                              valid_out,
    input  logic                              ready_in,
    output logic                              frame_done,
    output logic [FRAME_CNT_W-1:0]            frame_cnt,
    output logic                              err_short,
    output logic                              err_long,
    input  logic                              err_clr
);

    localparam int PW = ptr_w(FIFO_DEPTH);

    typedef struct packed {
        logic                            last;
        logic [C_S_AXIS_TDATA_WIDTH-1:0] data;
    } entry_t;

    entry_t      wr_entry, rd_entry;
    logic        fifo_full, fifo_empty;
    logic [PW:0] fifo_count;
    logic        push, pop;

    assign S_AXIS_TREADY = ~S_AXIS_ARESET & ~fifo_full;
    assign push          = S_AXIS_TVALID & S_AXIS_TREADY;
    assign valid_out     = ~fifo_empty;
    assign pop           = valid_out & ready_in;

    assign wr_entry.last = S_AXIS_TLAST;
    assign wr_entry.data = S_AXIS_TDATA;
    assign data_out      = rd_entry.data;
    assign last_out      = rd_entry.last;

    my_image_ip_sync_fifo #(
        .WIDTH (C_S_AXIS_TDATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (S_AXIS_ACLK),
        .rst_i   (S_AXIS_ARESET),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    logic                   frame_done_q, frame_done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_done_d = push & S_AXIS_TLAST;
        frame_cnt_d  = frame_cnt_q;
        if (push && S_AXIS_TLAST) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

`ifdef MY_IMAGE_IP_FRAME_CHECK_EN
    localparam int BW = $clog2(FRAME_WORDS) + 1;

    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [BW:0]   beat_next;
    logic          err_short_q, err_short_d;
    logic          err_long_q, err_long_d;
    logic          set_short, set_long;

    // One extra bit so the +1 compare never aliases when the counter is saturated.
    assign beat_next = {1'b0, beat_cnt_q} + (BW+1)'(1);
    assign set_short = push & S_AXIS_TLAST & (beat_next < (BW+1)'(FRAME_WORDS));
    assign set_long  = push & ~S_AXIS_TLAST & (beat_next == (BW+1)'(FRAME_WORDS));

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (push) begin
            if (S_AXIS_TLAST) begin
                beat_cnt_d = '0;
            end else if (beat_cnt_q != '1) begin
                beat_cnt_d = beat_next[BW-1:0];
            end
        end
        err_short_d = set_short ? 1'b1 : (err_clr ? 1'b0 : err_short_q);
        err_long_d  = set_long  ? 1'b1 : (err_clr ? 1'b0 : err_long_q);
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            beat_cnt_q  <= '0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    assign err_short = err_short_q;
    assign err_long  = err_long_q;

    logic unused_sigs;
    assign unused_sigs = &{1'b0, S_AXIS_TSTRB, fifo_count};
`else
    assign err_short = 1'b0;
    assign err_long  = 1'b0;

    logic unused_sigs;
    assign unused_sigs = &{1'b0, S_AXIS_TSTRB, fifo_count, err_clr};
`endif

endmodule

// File: tb/tb_my_image_ip_s00_axis_rx.sv
// tb/tb_my_image_ip_s00_axis_rx.sv - directed scoreboard bench for my_image_ip_s00_axis_rx
module tb_my_image_ip_s00_axis_rx;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int FW    = 8;
`ifdef MY_IMAGE_IP_FRAME_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tdata;
    logic [3:0]    tstrb;
    logic          tlast, tvalid, tready;
    logic [DW-1:0] data_out;
    logic          last_out, valid_out, ready_in;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic          err_short, err_long, err_clr;

    always #5 clk = ~clk;

    my_image_ip_s00_axis_rx #(
        .C_S_AXIS_TDATA_WIDTH (DW),
        .FIFO_DEPTH           (DEPTH),
        .FRAME_WORDS          (FW)
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESET (rst),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .data_out      (data_out),
        .last_out      (last_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .err_short     (err_short),
        .err_long      (err_long),
        .err_clr       (err_clr)
    );

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } ent_t;

    ent_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          m_beat = 0;
    logic [15:0] m_fcnt = '0;
    logic        m_fdone = 1'b0, m_es = 1'b0, m_el = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check registered state, model the handshakes, cross posedge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic l, input logic rdy,
                       input logic clr, input logic r, output logic acc);
        logic push, pop, set_s, set_l;
        ent_t e;
        @(negedge clk);
        rst = r; tvalid = v; tdata = d; tlast = l; ready_in = rdy; err_clr = clr;
        tstrb = 4'($urandom);
        #1;
        chk("valid_out",  64'(valid_out),  64'(sb.size() != 0));
        chk("tready",     64'(tready),     64'(!r && sb.size() != DEPTH));
        chk("frame_done", 64'(frame_done), 64'(m_fdone));
        chk("frame_cnt",  64'(frame_cnt),  64'(m_fcnt));
        chk("err_short",  64'(err_short),  64'(m_es));
        chk("err_long",   64'(err_long),   64'(m_el));
        acc  = v && tready && !r;
        push = !r && v && (sb.size() != DEPTH);
        pop  = !r && rdy && (sb.size() != 0);
        if (pop) begin
            e = sb.pop_front();
            chk("data_out", 64'(data_out), 64'(e.data));
            chk("last_out", 64'(last_out), 64'(e.last));
        end
        m_fdone = 1'b0;
        if (r) begin
            sb.delete();
            m_beat = 0; m_fcnt = '0; m_es = 1'b0; m_el = 1'b0;
        end else begin
            set_s = CHK_EN && push && l && (m_beat + 1 < FW);
            set_l = CHK_EN && push && !l && (m_beat + 1 == FW);
            if (push) begin
                e.last = l; e.data = d;
                sb.push_back(e);
                m_beat = l ? 0 : m_beat + 1;
                if (l) begin
                    m_fcnt  = m_fcnt + 16'd1;
                    m_fdone = 1'b1;
                end
            end
            m_es = set_s ? 1'b1 : (clr ? 1'b0 : m_es);
            m_el = set_l ? 1'b1 : (clr ? 1'b0 : m_el);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        logic a;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, rdy, 1'b0, 1'b0, a);
    endtask

    task automatic send(input int n, input logic [DW-1:0] base, input int last_at, input logic rdy);
        logic a;
        int k, g;
        k = 0; g = 0;
        while (k < n && g < 200) begin
            cyc(1'b1, base + DW'(k), (k + 1 == last_at), rdy, 1'b0, 1'b0, a);
            if (a) k++;
            g++;
        end
        chk("send_beats_accepted", 64'(k), 64'(n));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 64) begin
            idle(1, 1'b1);
            g++;
        end
        idle(1, 1'b1);
    endtask

    initial begin
        logic a;
        int k;
        rst = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0; tstrb = '0;
        ready_in = 1'b0; err_clr = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, a);

        // Streaming pass-through of four beats.
        for (int i = 0; i < 4; i++) cyc(1'b1, DW'(i), 1'b0, 1'b1, 1'b0, 1'b0, a);
        drain();

        // Back-pressure: only DEPTH of 20 offered beats fit.
        k = 0;
        for (int c = 0; c < 20; c++) begin
            cyc(1'b1, DW'(32'h100) + DW'(k), 1'b0, 1'b0, 1'b0, 1'b0, a);
            if (a) k++;
        end
        chk("accepted_while_stalled", 64'(k), 64'(DEPTH));
        send(20 - k, DW'(32'h100) + DW'(k), 0, 1'b1);
        drain();
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, a);

        // Exact-length frame.
        send(8, DW'(32'h200), 8, 1'b1);
        drain();
        chk("good_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("good_frame_no_err", 64'({err_short, err_long}), 64'd0);

        // Short frame, sticky flag, then clear.
        send(5, DW'(32'h300), 5, 1'b1);
        idle(3, 1'b1);
        chk("short_sticky", 64'(err_short), 64'(CHK_EN));
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, a);
        idle(1, 1'b1);
        chk("short_cleared", 64'(err_short), 64'd0);

        // Set wins over a same-cycle clear.
        send(2, DW'(32'h380), 0, 1'b1);
        cyc(1'b1, DW'(32'h382), 1'b1, 1'b1, 1'b1, 1'b0, a);
        idle(2, 1'b1);
        chk("short_set_beats_clr", 64'(err_short), 64'(CHK_EN));
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, a);

        // Long frame, then a clean frame after clearing.
        send(10, DW'(32'h400), 10, 1'b1);
        idle(2, 1'b1);
        chk("long_sticky", 64'(err_long), 64'(CHK_EN));
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, a);
        send(8, DW'(32'h500), 8, 1'b1);
        drain();
        chk("after_long_clean", 64'({err_short, err_long}), 64'd0);
        chk("frames_so_far", 64'(frame_cnt), 64'd5);

        // Reset in the middle of a frame with data still buffered.
        send(3, DW'(32'h600), 0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, a);
        idle(1, 1'b0);
        chk("post_reset_valid", 64'(valid_out), 64'd0);
        chk("post_reset_frame_cnt", 64'(frame_cnt), 64'd0);
        send(8, DW'(32'h700), 8, 1'b1);
        drain();
        chk("post_reset_frame", 64'(frame_cnt), 64'd1);
        chk("post_reset_no_err", 64'({err_short, err_long}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
